// File: rtl/clock_time_ctrl_if.sv
// rtl/clock_time_ctrl_if.sv - tick/button inputs and BCD display outputs of clock_time_ctrl
//
// Signals:
//   tick_1hz, btn_mode, btn_inc : single-cycle pulses into the controller
//   hr_*, min_*, sec_*          : BCD digits to the 7-segment mux
//   pm, set_sel, blink          : display qualifiers
//   day_pulse                   : one-cycle pulse on midnight rollover
// Modports: master drives the pulses and observes the display; slave is the controller.

interface clock_time_ctrl_if;
   logic       tick_1hz;
   logic       btn_mode;
   logic       btn_inc;
   logic [3:0] hr_tens;
   logic [3:0] hr_ones;
   logic [3:0] min_tens;
   logic [3:0] min_ones;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       pm;
   logic [1:0] set_sel;
   logic       blink;
   logic       day_pulse;

   modport master (
      output tick_1hz, btn_mode, btn_inc,
      input  hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
      input  pm, set_sel, blink, day_pulse
   );

   modport slave (
      input  tick_1hz, btn_mode, btn_inc,
      output hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
      output pm, set_sel, blink, day_pulse
   );
endinterface

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - HH:MM:SS BCD timekeeper with hour/minute set-mode FSM
//
// Ports:
//   clk      : system clock
//   reset    : synchronous active-high reset
//   io       : clock_time_ctrl_if.slave (tick/button pulses in, BCD digits, pm,
//              set_sel, blink, day_pulse out); all outputs registered
// Parameter:
//   HOUR_24  : 1 = hours 00..23; 0 = hours 01..12 with pm flag
// Optional feature macro: SET_BLINK_EN (blink register toggling per tick while
//   a field is being set; when undefined blink is tied to 0)

module clock_time_ctrl #(
   parameter bit HOUR_24 = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   clock_time_ctrl_if.slave io
);

   typedef enum logic [1:0] {
      RUN     = 2'b00,
      SET_HR  = 2'b01,
      SET_MIN = 2'b10
   } state_t;

   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
   } bcd2_t;

   typedef struct packed {
      logic  carry;
      bcd2_t val;
   } bcd_inc_t;

   typedef struct packed {
      logic  wrap;
      logic  pm_toggle;
      bcd2_t val;
   } hr_inc_t;

   localparam bcd2_t HR_RESET = bcd2_t'(HOUR_24 ? 8'h00 : 8'h12);

   // Seconds/minutes: 00..59. An out-of-range digit snaps the field to 00
   // without a carry, since the field never legitimately reached 59.
   function automatic bcd_inc_t inc_base60(bcd2_t v);
      bcd_inc_t r;
      r.carry = 1'b0;
      r.val   = v;
      if (v.tens > 4'd5 || v.ones > 4'd9) begin
         r.val = bcd2_t'(8'h00);
      end else if (v.ones == 4'd9) begin
         r.val.ones = 4'd0;
         if (v.tens == 4'd5) begin
            r.val.tens = 4'd0;
            r.carry    = 1'b1;
         end else begin
            r.val.tens = v.tens + 4'd1;
         end
      end else begin
         r.val.ones = v.ones + 4'd1;
      end
      return r;
   endfunction

   // Hours: wrap marks the 23->00 rollover (24h); pm_toggle marks 11->12 (12h).
   // Out-of-range values snap to the wrap value (00 or 01) with no side effects.
   function automatic hr_inc_t inc_hour(bcd2_t v);
      hr_inc_t r;
      r.wrap      = 1'b0;
      r.pm_toggle = 1'b0;
      r.val       = v;
      if (HOUR_24) begin
         if (v.tens > 4'd2 || v.ones > 4'd9 || (v.tens == 4'd2 && v.ones > 4'd3)) begin
            r.val = bcd2_t'(8'h00);
         end else if (v.tens == 4'd2 && v.ones == 4'd3) begin
            r.val  = bcd2_t'(8'h00);
            r.wrap = 1'b1;
         end else if (v.ones == 4'd9) begin
            r.val.tens = v.tens + 4'd1;
            r.val.ones = 4'd0;
         end else begin
            r.val.ones = v.ones + 4'd1;
         end
      end else begin
         // 12 -> 01 is the normal wrap and shares the illegal-value path.
         if (v.tens > 4'd1 || v.ones > 4'd9 || (v.tens == 4'd1 && v.ones >= 4'd2)) begin
            r.val = bcd2_t'(8'h01);
         end else if (v.tens == 4'd1 && v.ones == 4'd1) begin
            r.val       = bcd2_t'(8'h12);
            r.pm_toggle = 1'b1;
         end else if (v.ones == 4'd9) begin
            r.val.tens = v.tens + 4'd1;
            r.val.ones = 4'd0;
         end else begin
            r.val.ones = v.ones + 4'd1;
         end
      end
      return r;
   endfunction

   state_t   state_q, state_d;
   bcd2_t    hr_q, hr_d;
   bcd2_t    min_q, min_d;
   bcd2_t    sec_q, sec_d;
   logic     pm_q, pm_d;
   logic     day_q, day_d;

   bcd_inc_t sec_inc;
   bcd_inc_t min_inc;
   hr_inc_t  hr_inc;
   logic     hr_day;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         hr_q    <= HR_RESET;
         min_q   <= bcd2_t'(8'h00);
         sec_q   <= bcd2_t'(8'h00);
         pm_q    <= 1'b0;
         day_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hr_q    <= hr_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         pm_q    <= pm_d;
         day_q   <= day_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hr_d    = hr_q;
      min_d   = min_q;
      sec_d   = sec_q;
      pm_d    = pm_q;
      day_d   = 1'b0;

      sec_inc = inc_base60(sec_q);
      min_inc = inc_base60(min_q);
      hr_inc  = inc_hour(hr_q);
      // Midnight: 23->00 in 24h mode, or 11->12 while pm is set in 12h mode.
      hr_day  = HOUR_24 ? hr_inc.wrap : (hr_inc.pm_toggle & pm_q);

      case (state_q)
         RUN: begin
            if (io.tick_1hz) begin
               sec_d = sec_inc.val;
               if (sec_inc.carry) begin
                  min_d = min_inc.val;
                  if (min_inc.carry) begin
                     hr_d  = hr_inc.val;
                     pm_d  = pm_q ^ hr_inc.pm_toggle;
                     day_d = hr_day;
                  end
               end
            end
         end
         SET_HR: begin
            // btn_mode in the same cycle drops the increment.
            if (io.btn_inc && !io.btn_mode) begin
               hr_d = hr_inc.val;
               pm_d = pm_q ^ hr_inc.pm_toggle;
            end
         end
         SET_MIN: begin
            if (io.btn_inc && !io.btn_mode) begin
               min_d = min_inc.val;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (io.btn_mode) begin
         case (state_q)
            RUN:     state_d = SET_HR;
            SET_HR:  state_d = SET_MIN;
            default: state_d = RUN;
         endcase
         // Entering hour-set clears seconds, overriding any tick update above
         // while keeping its carry into minutes/hours.
         if (state_d == SET_HR) begin
            sec_d = bcd2_t'(8'h00);
         end
      end
   end

`ifdef SET_BLINK_EN
   logic blink_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         blink_q <= 1'b0;
      end else if (state_d == RUN) begin
         blink_q <= 1'b0;
      end else if (io.tick_1hz && state_q != RUN) begin
         blink_q <= ~blink_q;
      end
   end

   assign io.blink = blink_q;
`else
   assign io.blink = 1'b0;
`endif

   assign io.hr_tens   = hr_q.tens;
   assign io.hr_ones   = hr_q.ones;
   assign io.min_tens  = min_q.tens;
   assign io.min_ones  = min_q.ones;
   assign io.sec_tens  = sec_q.tens;
   assign io.sec_ones  = sec_q.ones;
   assign io.pm        = HOUR_24 ? 1'b0 : pm_q;
   assign io.set_sel   = state_q;
   assign io.day_pulse = day_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - self-checking bench for clock_time_ctrl in 24h and 12h builds

module tb_clock_time_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   clock_time_ctrl_if if24 ();
   clock_time_ctrl_if if12 ();

   clock_time_ctrl #(.HOUR_24(1'b1)) dut24 (.clk(clk), .reset(reset), .io(if24));
   clock_time_ctrl #(.HOUR_24(1'b0)) dut12 (.clk(clk), .reset(reset), .io(if12));

`ifdef SET_BLINK_EN
   localparam bit BLINK_EN = 1'b1;
`else
   localparam bit BLINK_EN = 1'b0;
`endif

   int vectors = 0;
   int errors  = 0;

   // Reference model, index 0 = 24h instance, 1 = 12h instance.
   // Time is held as plain integers; mode is 0 run, 1 set hours, 2 set minutes.
   int m_hr[2];
   int m_min[2];
   int m_sec[2];
   bit m_pm[2];
   int m_st[2];
   bit m_blink[2];
   bit m_day[2];

   function automatic void model_reset(int k);
      m_hr[k]    = (k == 0) ? 0 : 12;
      m_min[k]   = 0;
      m_sec[k]   = 0;
      m_pm[k]    = 1'b0;
      m_st[k]    = 0;
      m_blink[k] = 1'b0;
      m_day[k]   = 1'b0;
   endfunction

   // Advance the hour by one; returns 1 when the clock reaches midnight.
   function automatic bit hour_up(int k);
      if (k == 0) begin
         m_hr[k] = (m_hr[k] + 1) % 24;
         return (m_hr[k] == 0);
      end
      if (m_hr[k] == 11) begin
         m_hr[k] = 12;
         m_pm[k] = ~m_pm[k];
         return (m_pm[k] == 1'b0);
      end
      m_hr[k] = (m_hr[k] % 12) + 1;
      return 1'b0;
   endfunction

   function automatic void model_step(int k, bit t, bit m, bit i);
      bit day = 1'b0;
      int st  = m_st[k];
      bit dummy;
      if (st == 0 && t) begin
         m_sec[k]++;
         if (m_sec[k] == 60) begin
            m_sec[k] = 0;
            m_min[k]++;
            if (m_min[k] == 60) begin
               m_min[k] = 0;
               day = hour_up(k);
            end
         end
      end
      if (m) begin
         m_st[k] = (st + 1) % 3;
         if (m_st[k] == 1) m_sec[k] = 0;
      end else if (i && st == 1) begin
         dummy = hour_up(k);
      end else if (i && st == 2) begin
         m_min[k] = (m_min[k] + 1) % 60;
      end
      if (!BLINK_EN || m_st[k] == 0) m_blink[k] = 1'b0;
      else if (st != 0 && t)         m_blink[k] = ~m_blink[k];
      m_day[k] = day;
   endfunction

   function automatic logic [28:0] exp_vec(int k);
      return {4'(m_hr[k] / 10), 4'(m_hr[k] % 10), 4'(m_min[k] / 10), 4'(m_min[k] % 10),
              4'(m_sec[k] / 10), 4'(m_sec[k] % 10), m_pm[k], 2'(m_st[k]), m_blink[k], m_day[k]};
   endfunction

   function automatic logic [28:0] act_vec(int k);
      if (k == 0)
         return {if24.hr_tens, if24.hr_ones, if24.min_tens, if24.min_ones, if24.sec_tens,
                 if24.sec_ones, if24.pm, if24.set_sel, if24.blink, if24.day_pulse};
      return {if12.hr_tens, if12.hr_ones, if12.min_tens, if12.min_ones, if12.sec_tens,
              if12.sec_ones, if12.pm, if12.set_sel, if12.blink, if12.day_pulse};
   endfunction

   task automatic drive(input bit t, input bit m, input bit i);
      if24.tick_1hz = t; if24.btn_mode = m; if24.btn_inc = i;
      if12.tick_1hz = t; if12.btn_mode = m; if12.btn_inc = i;
   endtask

   task automatic apply(input bit t, input bit m, input bit i);
      drive(t, m, i);
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) model_step(k, t, m, i);
      drive(1'b0, 1'b0, 1'b0);
   endtask

   // Reset optionally with all pulses asserted, which reset must override.
   task automatic do_reset(input bit noisy);
      reset = 1'b1;
      drive(noisy, noisy, noisy);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) model_reset(k);
   endtask

   task automatic test_reset;
      do_reset(1'b0);
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (act_vec(k) !== exp_vec(k)) begin
            errors++;
            $display("FAIL reset dut%0d got %h expected %h", k, act_vec(k), exp_vec(k));
         end
      end
      vectors++;
      if (act_vec(0) !== 29'h0) begin
         errors++;
         $display("FAIL reset24_zero got %h expected %h", act_vec(0), 29'h0);
      end
      vectors++;
      if ({if12.hr_tens, if12.hr_ones, if12.pm} !== 9'h024) begin
         errors++;
         $display("FAIL reset12_hour got %h expected %h", {if12.hr_tens, if12.hr_ones, if12.pm}, 9'h024);
      end
      repeat (10) apply(1'b1, 1'b0, 1'b0);
      vectors++;
      if ({if24.sec_tens, if24.sec_ones} !== 8'h10) begin
         errors++;
         $display("FAIL ten_ticks got %h expected %h", {if24.sec_tens, if24.sec_ones}, 8'h10);
      end
   endtask

   task automatic test_day_rollover;
      do_reset(1'b0);
      apply(1'b0, 1'b1, 1'b0);
      repeat (23) apply(1'b0, 1'b0, 1'b1);
      apply(1'b0, 1'b1, 1'b0);
      repeat (59) apply(1'b0, 1'b0, 1'b1);
      apply(1'b0, 1'b1, 1'b0);
      repeat (59) apply(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (act_vec(k) !== exp_vec(k)) begin
            errors++;
            $display("FAIL preset_235959 dut%0d got %h expected %h", k, act_vec(k), exp_vec(k));
         end
      end
      apply(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (act_vec(k) !== exp_vec(k)) begin
            errors++;
            $display("FAIL midnight dut%0d got %h expected %h", k, act_vec(k), exp_vec(k));
         end
      end
      vectors++;
      if (act_vec(0) !== 29'h1) begin
         errors++;
         $display("FAIL midnight24 got %h expected %h", act_vec(0), 29'h1);
      end
      vectors++;
      if ({if12.hr_tens, if12.hr_ones, if12.pm, if12.day_pulse} !== 10'h049) begin
         errors++;
         $display("FAIL midnight12 got %h expected %h",
                  {if12.hr_tens, if12.hr_ones, if12.pm, if12.day_pulse}, 10'h049);
      end
      apply(1'b0, 1'b0, 1'b0);
      vectors++;
      if ({if24.day_pulse, if12.day_pulse} !== 2'b00) begin
         errors++;
         $display("FAIL day_pulse_width got %b expected %b", {if24.day_pulse, if12.day_pulse}, 2'b00);
      end
   endtask

   task automatic test_noon_12h;
      do_reset(1'b0);
      apply(1'b0, 1'b1, 1'b0);
      repeat (11) apply(1'b0, 1'b0, 1'b1);
      apply(1'b0, 1'b1, 1'b0);
      repeat (59) apply(1'b0, 1'b0, 1'b1);
      apply(1'b0, 1'b1, 1'b0);
      repeat (59) apply(1'b1, 1'b0, 1'b0);
      vectors++;
      if ({if12.hr_tens, if12.hr_ones, if12.pm} !== 9'h022) begin
         errors++;
         $display("FAIL pre_noon12 got %h expected %h", {if12.hr_tens, if12.hr_ones, if12.pm}, 9'h022);
      end
      apply(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (act_vec(k) !== exp_vec(k)) begin
            errors++;
            $display("FAIL noon dut%0d got %h expected %h", k, act_vec(k), exp_vec(k));
         end
      end
      vectors++;
      if ({if12.hr_tens, if12.hr_ones, if12.pm, if12.day_pulse} !== 10'h04a) begin
         errors++;
         $display("FAIL noon12 got %h expected %h",
                  {if12.hr_tens, if12.hr_ones, if12.pm, if12.day_pulse}, 10'h04a);
      end
   endtask

   task automatic test_set_freeze;
      do_reset(1'b0);
      repeat (5) apply(1'b1, 1'b0, 1'b0);
      apply(1'b0, 1'b1, 1'b0);
      vectors++;
      if ({if24.set_sel, if24.sec_tens, if24.sec_ones} !== 10'h100) begin
         errors++;
         $display("FAIL enter_set_hr got %h expected %h", {if24.set_sel, if24.sec_tens, if24.sec_ones}, 10'h100);
      end
      repeat (30) begin
         apply(1'b1, 1'b0, 1'b0);
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (act_vec(k) !== exp_vec(k)) begin
               errors++;
               $display("FAIL frozen dut%0d got %h expected %h", k, act_vec(k), exp_vec(k));
            end
         end
      end
      repeat (25) apply(1'b0, 1'b0, 1'b1);
      vectors++;
      if ({if24.hr_tens, if24.hr_ones, if24.min_tens, if24.min_ones} !== 16'h0100) begin
         errors++;
         $display("FAIL inc25_hr got %h expected %h",
                  {if24.hr_tens, if24.hr_ones, if24.min_tens, if24.min_ones}, 16'h0100);
      end
      vectors++;
      if (act_vec(1) !== exp_vec(1)) begin
         errors++;
         $display("FAIL inc25_hr12 got %h expected %h", act_vec(1), exp_vec(1));
      end
   endtask

   task automatic test_simultaneous;
      apply(1'b0, 1'b1, 1'b1);
      vectors++;
      if ({if24.set_sel, if24.hr_tens, if24.hr_ones} !== 10'h201) begin
         errors++;
         $display("FAIL mode_inc got %h expected %h", {if24.set_sel, if24.hr_tens, if24.hr_ones}, 10'h201);
      end
      do_reset(1'b0);
      repeat (59) apply(1'b1, 1'b0, 1'b0);
      apply(1'b1, 1'b1, 1'b0);
      vectors++;
      if (act_vec(0) !== {24'h000100, 1'b0, 2'b01, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL tick_mode got %h expected %h", act_vec(0), {24'h000100, 1'b0, 2'b01, 1'b0, 1'b0});
      end
      vectors++;
      if (act_vec(1) !== exp_vec(1)) begin
         errors++;
         $display("FAIL tick_mode12 got %h expected %h", act_vec(1), exp_vec(1));
      end
   endtask

   task automatic test_blink;
      do_reset(1'b0);
      apply(1'b0, 1'b1, 1'b0);
      apply(1'b0, 1'b1, 1'b0);
      for (int n = 1; n <= 3; n++) begin
         apply(1'b1, 1'b0, 1'b0);
         vectors++;
         if (if24.blink !== (BLINK_EN & n[0])) begin
            errors++;
            $display("FAIL blink_tick%0d got %b expected %b", n, if24.blink, BLINK_EN & n[0]);
         end
      end
      apply(1'b0, 1'b1, 1'b0);
      vectors++;
      if ({if24.set_sel, if24.blink} !== 3'b000) begin
         errors++;
         $display("FAIL blink_run got %b expected %b", {if24.set_sel, if24.blink}, 3'b000);
      end
   endtask

   task automatic test_reset_mid_set;
      apply(1'b0, 1'b1, 1'b0);
      repeat (3) apply(1'b0, 1'b0, 1'b1);
      do_reset(1'b1);
      for (int k = 0; k < 2; k++) begin
         vectors++;
         if (act_vec(k) !== exp_vec(k)) begin
            errors++;
            $display("FAIL reset_mid_set dut%0d got %h expected %h", k, act_vec(k), exp_vec(k));
         end
      end
   endtask

   task automatic test_random;
      do_reset(1'b0);
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 499) == 0) do_reset(1'b1);
         else apply($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0);
         for (int k = 0; k < 2; k++) begin
            vectors++;
            if (act_vec(k) !== exp_vec(k)) begin
               errors++;
               $display("FAIL random c%0d dut%0d got %h expected %h", c, k, act_vec(k), exp_vec(k));
            end
         end
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      test_reset;
      test_day_rollover;
      test_noon_12h;
      test_set_freeze;
      test_simultaneous;
      test_blink;
      test_reset_mid_set;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
